lmsm_sequencer: RTL

- Initiator-side sequencer for multi-register transfers (LM/SM) in the IITB-RISC pipeline.
- Walks an 8-bit register mask and issues one register-file access per cycle:
  - SM: reads a register and writes it to memory.
  - LM: reads memory and writes the value into a register.
- Drives the register-file read port and write port 1.
- Holds the pipeline stalled until the mask is exhausted.

---
 rtl/lmsm_sequencer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/lmsm_sequencer.sv
// Initiator-side LM/SM sequencer: walks an 8-bit register mask and issues one
// register-file/memory transfer per cycle, stalling the pipeline while busy.
module lmsm_sequencer #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int ADDR_STEP = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_load,
    input  logic [7:0]        mask,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [2:0]        reg_read_addr,
    input  logic [DATA_W-1:0] reg_read_data,
    output logic              reg_write_en,
    output logic [2:0]        reg_write_dest,
    output logic [DATA_W-1:0] reg_write_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        rem_mask_q, rem_mask_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic              mode_q, mode_d;
    logic [2:0]        idx_s;

    // R0 has the highest priority, so scan downwards and keep the last hit.
    function automatic logic [2:0] lowest_idx(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) begin
                r = 3'(i);
            end
        end
        return r;
    endfunction

    // True when at most one bit remains, i.e. this is the final transfer.
    function automatic logic last_bit(input logic [7:0] m);
        return (m & (m - 8'd1)) == 8'd0;
    endfunction

    assign idx_s = lowest_idx(rem_mask_q);

    // Next-state, datapath updates and combinational transfer outputs.
    always_comb begin
        state_d        = state_q;
        rem_mask_d     = rem_mask_q;
        cur_addr_d     = cur_addr_q;
        mode_d         = mode_q;
        reg_read_addr  = 3'd0;
        reg_write_en   = 1'b0;
        reg_write_dest = 3'd0;
        reg_write_data = '0;
        mem_addr       = '0;
        mem_we         = 1'b0;
        mem_re         = 1'b0;
        mem_wdata      = '0;
        busy           = 1'b0;
        done           = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rem_mask_d = mask;
                    cur_addr_d = base_addr;
                    mode_d     = is_load;
                    if (mask != 8'd0) begin
                        state_d = ST_XFER;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_XFER: begin
                busy     = 1'b1;
                mem_addr = cur_addr_q;
                if (mode_q) begin
                    mem_re         = 1'b1;
                    reg_write_en   = 1'b1;
                    reg_write_dest = idx_s;
                    reg_write_data = mem_rdata;
                end else begin
                    reg_read_addr = idx_s;
                    mem_we        = 1'b1;
                    mem_wdata     = reg_read_data;
                end
                rem_mask_d = rem_mask_q & ~(8'd1 << idx_s);
                // Address arithmetic is modulo 2^ADDR_W, so the top word wraps to 0.
                cur_addr_d = cur_addr_q + ADDR_W'(ADDR_STEP);
                if (last_bit(rem_mask_q)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_XFER;
                end
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and working registers; reset aborts any transfer in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rem_mask_q <= 8'd0;
            cur_addr_q <= '0;
            mode_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_mask_q <= rem_mask_d;
            cur_addr_q <= cur_addr_d;
            mode_q     <= mode_d;
        end
    end

endmodule
